// File: rtl/ddr_hit_judge.sv
// Rhythm-game note judge: latches the lane pattern on each beat, then scores the
// player's key presses within a fixed window and tracks score, combo and lives.
module ddr_hit_judge #(
    parameter int WINDOW_CYC = 12_500_000,
    parameter int LIVES      = 3,
    parameter int SCORE_W    = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               beat,
    input  logic [2:0]         pattern,
    input  logic [2:0]         keys,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         combo,
    output logic [7:0]         max_combo,
    output logic [3:0]         lives,
    output logic               game_over
);

    localparam int CNT_W = $clog2(WINDOW_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_CYC - 1);

    typedef enum logic [1:0] {IDLE, WINDOW, DONE, OVER} state_t;

    state_t           state;
    logic [2:0]       target;
    logic [2:0]       acc;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       keys_q;

    logic [2:0] key_edge;
    logic [2:0] acc_n;
    logic       rest;
    logic       wrong;
    logic       complete;
    logic       late;
    logic       judge_hit;
    logic       judge_miss;
    logic       last_life;
    logic [7:0] combo_n;

    function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] dec_floor(input logic [3:0] v);
        return (v == 4'd0) ? v : v - 4'd1;
    endfunction

    // Judgement of the open note for this cycle; a beat forces a verdict.
    always_comb begin
        key_edge   = keys & ~keys_q;
        acc_n      = acc | (key_edge & target);
        rest       = (target == 3'b000);
        wrong      = |(key_edge & ~target);
        complete   = (acc_n == target);
        late       = (cnt == CNT_LAST);
        judge_hit  = (state == WINDOW) && !rest && !wrong && complete;
        judge_miss = (state == WINDOW) && !rest && !judge_hit && (wrong || late || beat);
        last_life  = (lives <= 4'd1);
        combo_n    = sat_inc8(combo);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hit       <= 1'b0;
            miss      <= 1'b0;
            score     <= '0;
            combo     <= '0;
            max_combo <= '0;
            lives     <= 4'(LIVES);
            game_over <= 1'b0;
            target    <= '0;
            acc       <= '0;
            cnt       <= '0;
            keys_q    <= 3'b111;
        end else begin
            keys_q <= keys;
            hit    <= judge_hit;
            miss   <= judge_miss;

            if (judge_hit) begin
                score <= sat_inc_score(score);
                combo <= combo_n;
                if (combo_n > max_combo) begin
                    max_combo <= combo_n;
                end
            end
            if (judge_miss) begin
                combo <= '0;
                lives <= dec_floor(lives);
            end

            // Losing the last life wins over a simultaneous beat.
            if (judge_miss && last_life) begin
                state     <= OVER;
                game_over <= 1'b1;
            end else if (beat && state != OVER) begin
                state  <= WINDOW;
                target <= pattern;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == WINDOW) begin
                if (rest || judge_hit || judge_miss) begin
                    state <= DONE;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                    acc <= acc_n;
                end
            end
        end
    end

endmodule
